// File: rtl/rng_pkg.sv
// Shared defaults and types for the entropy harvester and its output FIFO.
package rng_pkg;

  localparam int SAMPLE_DIV = 8;
  localparam int WORD_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int REP_LIMIT  = 32;

  typedef enum logic {
    PAIR_FIRST,
    PAIR_SECOND
  } pair_state_e;

endpackage

// File: rtl/rng_fifo.sv
// Synchronous show-ahead word FIFO with a flush input; the head reads as zero when empty.
module rng_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [DATA_W-1:0]       data_i,
  input  logic                    pop_i,
  output logic [DATA_W-1:0]       head_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]    wr_q, wr_d;
  logic [PTR_W:0]    rd_q, rd_d;
  logic              full;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign count_o = wr_q - rd_q;
  assign empty_o = (count_o == '0);
  assign full    = (count_o == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_q[PTR_W-1:0]];

  always_comb begin
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop  ? rd_q + 1'b1 : rd_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: storage has no reset; only the pointers decide which entries are live, and the head is masked when empty.
  always_ff @(posedge Clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_q[PTR_W-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/entropy_harvester.sv
// Samples a raw entropy bit, von Neumann debiases it, packs words into a FIFO and
// runs a repetition-count health test that flushes and blocks output on failure.
module entropy_harvester #(
  parameter int SAMPLE_DIV = rng_pkg::SAMPLE_DIV,
  parameter int WORD_W     = rng_pkg::WORD_W,
  parameter int FIFO_DEPTH = rng_pkg::FIFO_DEPTH,
  parameter int REP_LIMIT  = rng_pkg::REP_LIMIT
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         rand_bit,
  input  logic                         rd_en,
  output logic [WORD_W-1:0]            rand_word,
  output logic                         word_valid,
  output logic [$clog2(FIFO_DEPTH):0]  fill_count,
  output logic                         health_fail
);

  import rng_pkg::*;

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int RUN_W = $clog2(REP_LIMIT + 1);

  logic [DIV_W-1:0]  div_q, div_d;
  pair_state_e       pair_q, pair_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              health_fail_q, health_fail_d;

  logic sample_stb;
  logic emit;
  logic word_done;
  logic push;
  logic pop;
  logic fifo_empty;

  assign sample_stb = (div_q == DIV_W'(SAMPLE_DIV - 1));

  // NOTE: every _d takes its _q value first, so no path through this block can infer a latch.
  always_comb begin
    div_d         = sample_stb ? '0 : div_q + 1'b1;
    pair_d        = pair_q;
    first_d       = first_q;
    last_d        = last_q;
    run_d         = run_q;
    acc_d         = acc_q;
    bit_cnt_d     = bit_cnt_q;
    health_fail_d = health_fail_q;
    emit          = 1'b0;
    word_done     = 1'b0;

    if (sample_stb) begin
      case (pair_q)
        PAIR_FIRST: begin
          first_d = rand_bit;
          pair_d  = PAIR_SECOND;
        end
        default: begin
          pair_d = PAIR_FIRST;
          emit   = (rand_bit != first_q);
        end
      endcase

      // A zero run count marks "no sample seen since reset".
      last_d = rand_bit;
      if (run_q == '0 || rand_bit != last_q) begin
        run_d = RUN_W'(1);
      end else if (run_q != RUN_W'(REP_LIMIT)) begin
        run_d = run_q + 1'b1;
      end
      if (run_d == RUN_W'(REP_LIMIT)) begin
        health_fail_d = 1'b1;
      end
    end

    if (emit) begin
      acc_d     = {acc_q[WORD_W-2:0], first_q};
      word_done = (bit_cnt_q == BIT_W'(WORD_W - 1));
      bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
    end
  end

  // A failure detected this cycle already blocks the push and flushes the FIFO.
  assign push = word_done && !health_fail_d;
  assign pop  = rd_en && word_valid;

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q         <= '0;
      pair_q        <= PAIR_FIRST;
      first_q       <= 1'b0;
      last_q        <= 1'b0;
      run_q         <= '0;
      acc_q         <= '0;
      bit_cnt_q     <= '0;
      health_fail_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pair_q        <= pair_d;
      first_q       <= first_d;
      last_q        <= last_d;
      run_q         <= run_d;
      acc_q         <= acc_d;
      bit_cnt_q     <= bit_cnt_d;
      health_fail_q <= health_fail_d;
    end
  end

  rng_fifo #(
    .DATA_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .flush_i (health_fail_d),
    .push_i  (push),
    .data_i  (acc_d),
    .pop_i   (pop),
    .head_o  (rand_word),
    .empty_o (fifo_empty),
    .count_o (fill_count)
  );

  assign word_valid  = !fifo_empty && !health_fail_q;
  assign health_fail = health_fail_q;

endmodule

// File: tb/tb_entropy_harvester.sv
// Self-checking bench: table vectors, directed corner sequences and random traffic
// compared each cycle against a sample/bit/word-level reference model.
module tb_entropy_harvester;

  localparam int SD = 8;
  localparam int WW = 16;
  localparam int FD = 4;
  localparam int RL = 32;
  localparam int CW = $clog2(FD) + 1;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          rand_bit = 1'b0;
  logic          rd_en = 1'b0;
  logic [WW-1:0] rand_word;
  logic          word_valid;
  logic [CW-1:0] fill_count;
  logic          health_fail;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  entropy_harvester #(
    .SAMPLE_DIV (SD),
    .WORD_W     (WW),
    .FIFO_DEPTH (FD),
    .REP_LIMIT  (RL)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .rand_bit    (rand_bit),
    .rd_en       (rd_en),
    .rand_word   (rand_word),
    .word_valid  (word_valid),
    .fill_count  (fill_count),
    .health_fail (health_fail)
  );

  // Reference model: cycle counter, raw sample history, emitted bit list, word queue.
  int            m_cyc;
  int            m_nsamp;
  int            m_run;
  bit            m_last;
  bit            m_have_first;
  bit            m_first;
  bit            m_fail;
  bit            m_bits[$];
  logic [WW-1:0] m_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_nsamp = 0; m_run = 0; m_last = 0;
    m_have_first = 0; m_first = 0; m_fail = 0;
    m_bits.delete();
    m_q.delete();
  endtask

  task automatic model_update(input logic b, input logic rd);
    bit            pop, push, newfail, accept;
    logic [WW-1:0] w;
    pop = rd && (m_q.size() > 0) && !m_fail;
    push = 0; newfail = 0; w = '0;
    if (m_cyc % SD == SD - 1) begin
      if (m_nsamp > 0 && b == m_last) m_run++;
      else m_run = 1;
      m_last = b;
      m_nsamp++;
      if (m_run >= RL) newfail = 1;
      if (!m_have_first) begin
        m_first = b;
        m_have_first = 1;
      end else begin
        m_have_first = 0;
        if (b != m_first) begin
          m_bits.push_back(m_first);
          if (m_bits.size() == WW) begin
            for (int i = 0; i < WW; i++) w[WW-1-i] = m_bits[i];
            m_bits.delete();
            push = 1;
          end
        end
      end
    end
    if (m_fail || newfail) begin
      m_fail = 1;
      m_q.delete();
    end else begin
      accept = (m_q.size() < FD) || pop;
      if (pop) void'(m_q.pop_front());
      if (push && accept) m_q.push_back(w);
    end
    m_cyc++;
  endtask

  task automatic check_model();
    logic [WW-1:0] exp_word;
    exp_word = (m_q.size() > 0) ? m_q[0] : '0;
    check("mdl_word",   32'(rand_word),   32'(exp_word));
    check("mdl_valid",  32'(word_valid),  32'((m_q.size() > 0) && !m_fail));
    check("mdl_fill",   32'(fill_count),  32'(m_q.size()));
    check("mdl_health", 32'(health_fail), 32'(m_fail));
  endtask

  task automatic step(input logic b, input logic rd);
    rand_bit = b;
    rd_en = rd;
    model_update(b, rd);
    @(posedge Clk);
    @(negedge Clk);
    check_model();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    rd_en = 1'b1;
    rand_bit = 1'($urandom_range(0, 1));
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    rd_en = 1'b0;
    model_reset();
    check("rst_word",   32'(rand_word),   32'h0);
    check("rst_valid",  32'(word_valid),  32'h0);
    check("rst_fill",   32'(fill_count),  32'h0);
    check("rst_health", 32'(health_fail), 32'h0);
  endtask

  task automatic send_sample(input logic b);
    repeat (SD) step(b, 1'b0);
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    for (int i = WW - 1; i >= 0; i--) begin
      send_sample(w[i]);
      send_sample(~w[i]);
    end
  endtask

  typedef struct {
    logic [31:0]   raw;
    logic [WW-1:0] exp_word;
  } vec_t;

  vec_t          vecs[5];
  logic [WW-1:0] words[5];

  initial begin
    // 32 raw samples, first sample in bit 31; expected word from the pairing rule.
    vecs[0] = '{raw: 32'h5555_5555, exp_word: 16'h0000};
    vecs[1] = '{raw: 32'hAAAA_AAAA, exp_word: 16'hFFFF};
    vecs[2] = '{raw: 32'h9999_9999, exp_word: 16'hAAAA};
    vecs[3] = '{raw: 32'h6666_6666, exp_word: 16'h5555};
    vecs[4] = '{raw: 32'hA5A5_A5A5, exp_word: 16'hCCCC};
    for (int k = 0; k < 5; k++) words[k] = 16'(16'h1111 * (k + 1));

    @(negedge Clk);
    do_reset();

    // Table vectors: word completes exactly on the 32nd sample edge.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int j = 0; j < 31; j++) send_sample(vecs[v].raw[31-j]);
      repeat (SD - 1) step(vecs[v].raw[0], 1'b0);
      check("tbl_pre_fill", 32'(fill_count), 32'h0);
      step(vecs[v].raw[0], 1'b0);
      check("tbl_word",   32'(rand_word),   32'(vecs[v].exp_word));
      check("tbl_valid",  32'(word_valid),  32'h1);
      check("tbl_fill",   32'(fill_count),  32'h1);
      check("tbl_health", 32'(health_fail), 32'h0);
      step(1'b0, 1'b1);
      check("tbl_pop_fill", 32'(fill_count), 32'h0);
      check("tbl_pop_word", 32'(rand_word),  32'h0);
    end

    // Equal pairs emit nothing and leave the bit count alone.
    do_reset();
    repeat (8) begin send_sample(1'b1); send_sample(1'b0); end
    repeat (3) begin
      send_sample(1'b1); send_sample(1'b1);
      send_sample(1'b0); send_sample(1'b0);
    end
    check("junk_fill", 32'(fill_count), 32'h0);
    repeat (8) begin send_sample(1'b0); send_sample(1'b1); end
    check("junk_word", 32'(rand_word),  32'h0000FF00);
    check("junk_fill2", 32'(fill_count), 32'h1);

    // Five words without reads: fifth discarded, then drained in order.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_word(words[k]);
      check("ovf_fill", 32'(fill_count), 32'(k < FD ? k + 1 : FD));
    end
    for (int k = 0; k < 4; k++) begin
      check("ovf_order", 32'(rand_word), 32'(words[k]));
      step(1'b0, 1'b1);
    end
    check("ovf_valid", 32'(word_valid), 32'h0);
    check("ovf_empty", 32'(fill_count), 32'h0);
    step(1'b0, 1'b1);
    check("ovf_ign_rd", 32'(fill_count), 32'h0);

    // Full FIFO, word completes on the same edge as a pop.
    do_reset();
    for (int k = 0; k < 4; k++) send_word(words[k]);
    for (int i = WW - 1; i >= 1; i--) begin
      send_sample(words[4][i]);
      send_sample(~words[4][i]);
    end
    send_sample(words[4][0]);
    repeat (SD - 1) step(~words[4][0], 1'b0);
    step(~words[4][0], 1'b1);
    check("pp_fill", 32'(fill_count), 32'h4);
    check("pp_head", 32'(rand_word),  32'(words[1]));
    repeat (3) step(1'b0, 1'b1);
    check("pp_tail", 32'(rand_word),  32'(words[4]));
    check("pp_fill2", 32'(fill_count), 32'h1);

    // Reset after 9 emitted bits: partial word is discarded.
    do_reset();
    repeat (9) begin send_sample(1'b1); send_sample(1'b0); end
    do_reset();
    repeat (7) begin send_sample(1'b0); send_sample(1'b1); end
    check("mid_rst_fill", 32'(fill_count), 32'h0);
    repeat (9) begin send_sample(1'b0); send_sample(1'b1); end
    check("mid_rst_word", 32'(rand_word),  32'h0);
    check("mid_rst_fill2", 32'(fill_count), 32'h1);

    // Stuck-at-1 source trips the repetition test.
    do_reset();
    send_word(16'hFFFF);
    repeat (RL - 1) send_sample(1'b1);
    repeat (SD - 1) step(1'b1, 1'b0);
    check("hf_before", 32'(health_fail), 32'h0);
    check("hf_before_fill", 32'(fill_count), 32'h1);
    step(1'b1, 1'b0);
    check("hf_set",   32'(health_fail), 32'h1);
    check("hf_fill",  32'(fill_count),  32'h0);
    check("hf_valid", 32'(word_valid),  32'h0);
    check("hf_word",  32'(rand_word),   32'h0);
    for (int i = 0; i < 40 * SD; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("hf_sticky", 32'(health_fail), 32'h1);
    do_reset();

    // Random traffic: rare reads first so the FIFO fills, then frequent reads.
    for (int i = 0; i < 12000; i++) begin
      if (i < 6000) step(1'($urandom_range(0, 1)), $urandom_range(0, 999) < 1);
      else          step(1'($urandom_range(0, 1)), $urandom_range(0, 99) < 40);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/entropy_harvester.md
ENTROPY_HARVESTER -- requirements
Module: entropy_harvester

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 8, meaning Clk cycles per raw sample of rand_bit.
REQ-002 SHALL have parameter WORD_W, default 16, meaning bits per output word.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning words buffered (power of two).
REQ-004 SHALL have parameter REP_LIMIT, default 32, meaning run length of identical raw samples that declares health failure.
REQ-005 Clk  input  1  sole clock; all logic on posedge Clk.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 rand_bit  input  1  entropy bit, already synchronized (ring-oscillator sampler output).
REQ-008 rd_en  input  1  consumer pop request.
REQ-009 rand_word  output  WORD_W  FIFO head word.
REQ-010 word_valid  output  1  FIFO non-empty and no health failure.
REQ-011 fill_count  output  $clog2(FIFO_DEPTH)+1  words held.
REQ-012 health_fail  output  1  sticky entropy-source failure flag.

Function
REQ-013 Sample divider SHALL count 0..SAMPLE_DIV-1 and wrap; one raw sample of rand_bit is taken on the cycle the count equals SAMPLE_DIV-1.
REQ-014 Debiaser SHALL pair consecutive raw samples (first, second); unequal pair emits one bit equal to first; equal pair emits nothing; pairing restarts after each second sample.
REQ-015 Emitted bits SHALL shift into an accumulator from LSB (acc <= {acc[WORD_W-2:0], bit}); bit counter 0..WORD_W-1.
REQ-016 On the WORD_W-th emitted bit the completed word SHALL be pushed; bit counter wraps to 0 same cycle; word_valid/fill_count reflect it the next cycle.
REQ-017 Push when fill_count==FIFO_DEPTH and no simultaneous pop SHALL discard the word; FIFO contents unchanged; accumulation continues.
REQ-018 Pop occurs when rd_en && word_valid; rand_word advances to next entry the following cycle; rd_en while word_valid==0 SHALL be ignored.
REQ-019 Simultaneous push and pop SHALL both take effect, including when full (fill_count unchanged).
REQ-020 Repetition test SHALL count consecutive identical raw samples (run length starts at 1 on change); when run length reaches REP_LIMIT, health_fail SHALL assert next cycle.
REQ-021 While health_fail==1: FIFO flushed (fill_count=0), word_valid=0, no pushes, sampling continues but results discarded; cleared only by Reset.
REQ-022 rand_word SHALL be 0 whenever fill_count==0.

Reset
REQ-023 Reset SHALL clear divider, pair state, accumulator, bit counter, run counter, FIFO pointers, health_fail.
REQ-024 After Reset: rand_word=0, word_valid=0, fill_count=0, health_fail=0; Reset mid-word discards partial bits; Reset dominates simultaneous rd_en/push.

Structure
REQ-025 Package rng_pkg SHALL hold default constants SAMPLE_DIV, WORD_W, FIFO_DEPTH, REP_LIMIT and the debiaser state enum {PAIR_FIRST, PAIR_SECOND}.
REQ-026 FIFO SHALL be sub-module rng_fifo (sync, show-ahead, flush input); remaining logic in entropy_harvester.

Verification
REQ-027 rand_bit alternating per sample (0,1,0,1...), defaults -> each pair emits 0; word 16'h0000 valid after 32 samples (256 Clk + 1); health_fail stays 0.
REQ-028 Pairs (1,0) x16 -> rand_word=16'hFFFF; pairs (1,1)/(0,0) interleaved -> no bits emitted, bit counter unchanged.
REQ-029 No rd_en, produce 5 words -> fill_count saturates at 4, fifth discarded; then rd_en 4 cycles -> words 1..4 in order, word_valid drops after fourth pop.
REQ-030 FIFO full, word completes same cycle as pop -> fill_count stays 4, new word at tail.
REQ-031 rand_bit held 1 -> health_fail=1 one cycle after 32nd raw sample; FIFO flushed, word_valid=0; Reset clears all outputs to 0.
REQ-032 Reset asserted after 9 emitted bits -> next word built from fresh 16 bits only.
